// File: rtl/ni_cmd_write.sv
// NI write-command receiver: 3-byte serial command (opcode/addr, MSB, LSB) into HEMT control registers.
// Optional HVDC_RAMP_EN: hvdc_dac slews 1 LSB per RAMP_DIV clks toward a written target.
module ni_cmd_write #(
  parameter int TIMEOUT  = 1000,
  parameter int RAMP_DIV = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        swin,
  output logic        hvon,
  output logic [19:0] hven_n,
  output logic [7:0]  hvdc_dac,
  output logic [7:0]  bias_dac,
  output logic [7:0]  thrsh_dac,
  output logic        gain,
  output logic        busy,
  output logic        wr_done,
  output logic        cmd_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [5:0] A_HVON    = 6'h21;
  localparam logic [5:0] A_HVDC    = 6'h22;
  localparam logic [5:0] A_BIAS    = 6'h23;
  localparam logic [5:0] A_THRSH   = 6'h24;
  localparam logic [5:0] A_HVEN_HI = 6'h25;
  localparam logic [5:0] A_HVEN_LO = 6'h26;
  localparam logic [5:0] A_GAIN    = 6'h29;

  typedef enum logic [1:0] {IDLE, ADDR, MSB, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [5:0]      addr;
  logic [7:0]      msb, lsb;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit, addr_ok, wr_en, done_nxt, err_nxt;

  assign busy    = (state != IDLE);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Read-only alarm words and unmapped addresses fall to default; an hvon=1
  // request without the safety switch closed is refused outright.
  always_comb begin
    addr_ok = 1'b0;
    case (addr)
      A_HVON:                                          addr_ok = !(lsb[1] && !swin);
      A_HVDC, A_BIAS, A_THRSH, A_HVEN_HI, A_HVEN_LO, A_GAIN: addr_ok = 1'b1;
      default:                                         addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_data[7:6] == 2'b10) state_nxt = ADDR;
        else                       err_nxt   = 1'b1;
      end
      ADDR: if (rx_valid) state_nxt = MSB;
            else if (tmo_hit) begin state_nxt = IDLE; err_nxt = 1'b1; end
      MSB:  if (rx_valid) state_nxt = COMMIT;
            else if (tmo_hit) begin state_nxt = IDLE; err_nxt = 1'b1; end
      COMMIT: begin
        state_nxt = IDLE;
        // A stray byte here means the link is out of step; drop the whole command.
        if (rx_valid)     err_nxt = 1'b1;
        else if (addr_ok) begin wr_en = 1'b1; done_nxt = 1'b1; end
        else              err_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      msb       <= '0;
      lsb       <= '0;
      tmo_cnt   <= '0;
      wr_done   <= 1'b0;
      cmd_err   <= 1'b0;
      hvon      <= 1'b0;
      hven_n    <= 20'hFFFFF;
      bias_dac  <= '0;
      thrsh_dac <= '0;
      gain      <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_done <= done_nxt;
      cmd_err <= err_nxt;
      if (state == IDLE && rx_valid) addr <= rx_data[5:0];
      if (state == ADDR && rx_valid) msb  <= rx_data;
      if (state == MSB  && rx_valid) lsb  <= rx_data;
      if (rx_valid || !(state == ADDR || state == MSB)) tmo_cnt <= '0;
      else                                              tmo_cnt <= tmo_cnt + 1'b1;
      // Safety switch wins over any write, in every state.
      if (!swin)                        hvon <= 1'b0;
      else if (wr_en && addr == A_HVON) hvon <= lsb[1];
      if (wr_en) begin
        case (addr)
          A_BIAS:    bias_dac       <= lsb;
          A_THRSH:   thrsh_dac      <= lsb;
          A_HVEN_HI: hven_n[19:16]  <= lsb[3:0];
          A_HVEN_LO: hven_n[15:0]   <= {msb, lsb};
          A_GAIN:    gain           <= lsb[0];
          default:   ;
        endcase
      end
    end
  end

`ifdef HVDC_RAMP_EN
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [7:0]    hvdc_tgt;
  logic [RW-1:0] ramp_cnt;
  logic          ramp_tick;

  assign ramp_tick = (ramp_cnt == RW'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hvdc_tgt <= '0;
      ramp_cnt <= '0;
      hvdc_dac <= '0;
    end else begin
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      if (!swin || !hvon)                    hvdc_tgt <= '0;
      else if (wr_en && addr == A_HVDC)      hvdc_tgt <= lsb;
      if (ramp_tick) begin
        if (hvdc_dac < hvdc_tgt)      hvdc_dac <= hvdc_dac + 1'b1;
        else if (hvdc_dac > hvdc_tgt) hvdc_dac <= hvdc_dac - 1'b1;
      end
    end
  end
`else
  logic unused_ramp;
  assign unused_ramp = (RAMP_DIV > 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          hvdc_dac <= '0;
    else if (wr_en && addr == A_HVDC) hvdc_dac <= lsb;
  end
`endif

endmodule

// File: tb/tb_ni_cmd_write.sv
// Directed bench for ni_cmd_write: reference register model plus an expected-response queue.
module tb_ni_cmd_write;
  localparam int TMO  = 40;
  localparam int RDIV = 4;

  logic        clk, rst, rx_valid, swin;
  logic [7:0]  rx_data;
  logic        hvon, gain, busy, wr_done, cmd_err;
  logic [19:0] hven_n;
  logic [7:0]  hvdc_dac, bias_dac, thrsh_dac;

  ni_cmd_write #(.TIMEOUT(TMO), .RAMP_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .swin(swin),
    .hvon(hvon), .hven_n(hven_n), .hvdc_dac(hvdc_dac), .bias_dac(bias_dac),
    .thrsh_dac(thrsh_dac), .gain(gain), .busy(busy), .wr_done(wr_done), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        err;
    logic        hvon;
    logic [19:0] hven_n;
    logic [7:0]  hvdc, bias, thrsh;
    logic        gain;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference register model
  logic        m_hvon, m_gain;
  logic [19:0] m_hven;
  logic [7:0]  m_hvdc, m_bias, m_thrsh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_hvon = 1'b0; m_gain = 1'b0; m_hven = 20'hFFFFF;
    m_hvdc = 8'h00; m_bias = 8'h00; m_thrsh = 8'h00;
  endtask

  task automatic push_exp(input logic done);
    exp_t e;
    e.done = done; e.err = !done; e.hvon = m_hvon; e.hven_n = m_hven;
    e.hvdc = m_hvdc; e.bias = m_bias; e.thrsh = m_thrsh; e.gain = m_gain;
    sb.push_back(e);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".hvon"},  32'(hvon),      32'(m_hvon));
    chk({tag, ".hven"},  32'(hven_n),    32'(m_hven));
    chk({tag, ".hvdc"},  32'(hvdc_dac),  32'(m_hvdc));
    chk({tag, ".bias"},  32'(bias_dac),  32'(m_bias));
    chk({tag, ".thrsh"}, 32'(thrsh_dac), 32'(m_thrsh));
    chk({tag, ".gain"},  32'(gain),      32'(m_gain));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0); send_byte(b1); send_byte(b2);
  endtask

  // Response must appear exactly lat negedges later, last exactly one cycle.
  task automatic check_resp(input string tag, input int lat);
    exp_t e;
    repeat (lat) @(negedge clk);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: scoreboard empty got 0 want 1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".wr_done"}, 32'(wr_done),   32'(e.done));
      chk({tag, ".cmd_err"}, 32'(cmd_err),   32'(e.err));
      chk({tag, ".hvon"},    32'(hvon),      32'(e.hvon));
      chk({tag, ".hven"},    32'(hven_n),    32'(e.hven_n));
      chk({tag, ".hvdc"},    32'(hvdc_dac),  32'(e.hvdc));
      chk({tag, ".bias"},    32'(bias_dac),  32'(e.bias));
      chk({tag, ".thrsh"},   32'(thrsh_dac), 32'(e.thrsh));
      chk({tag, ".gain"},    32'(gain),      32'(e.gain));
    end
    @(negedge clk);
    chk({tag, ".pulse"}, 32'({wr_done, cmd_err}), 32'(0));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; swin = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.busy",  32'(busy),    32'(0));
    chk("rst.pulse", 32'({wr_done, cmd_err}), 32'(0));
    chk_regs("rst");
    rst = 1'b0;

    // bias write with exact latency and busy window
    m_bias = 8'h5A; push_exp(1'b1);
    send_byte(8'hA3);
    chk("bias.busy1", 32'(busy), 32'(1));
    send_byte(8'h00); send_byte(8'h5A);
    chk("bias.commit_busy", 32'(busy),    32'(1));
    chk("bias.early_done",  32'(wr_done), 32'(0));
    check_resp("bias", 1);
    chk("bias.busy_end", 32'(busy), 32'(0));

    // channel enables, low then high half
    m_hven = 20'hF1234; push_exp(1'b1);
    send3(8'hA6, 8'h12, 8'h34); check_resp("hven_lo", 1);
    m_hven = 20'h31234; push_exp(1'b1);
    send3(8'hA5, 8'h00, 8'h03); check_resp("hven_hi", 1);

    // gain, and hvdc direct load in the default build
    m_gain = 1'b1; push_exp(1'b1);
    send3(8'hA9, 8'h00, 8'h01); check_resp("gain", 1);
`ifndef HVDC_RAMP_EN
    m_hvdc = 8'hC3; push_exp(1'b1);
    send3(8'hA2, 8'h00, 8'hC3); check_resp("hvdc", 1);
`endif

    // interlock
    swin = 1'b0; push_exp(1'b0);
    send3(8'hA1, 8'h00, 8'h02); check_resp("hvon_nosw", 1);
    swin = 1'b1; m_hvon = 1'b1; push_exp(1'b1);
    send3(8'hA1, 8'h00, 8'h02); check_resp("hvon_sw", 1);
    swin = 1'b0; m_hvon = 1'b0;
    @(negedge clk);
    chk("hvon_drop", 32'(hvon), 32'(0));
    swin = 1'b1;

    // read-only address and bad opcode
    push_exp(1'b0);
    send3(8'hA8, 8'hFF, 8'hFF); check_resp("ro_addr", 1);
    push_exp(1'b0);
    send_byte(8'h21); check_resp("bad_op", 0);
    chk("bad_op.busy", 32'(busy), 32'(0));

    // inter-byte timeout, then a clean retry
    push_exp(1'b0);
    send_byte(8'hA4);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo.early_err", 32'(cmd_err), 32'(0));
    chk("tmo.busy",      32'(busy),    32'(1));
    check_resp("tmo", 1);
    chk("tmo.idle", 32'(busy), 32'(0));
    m_thrsh = 8'h10; push_exp(1'b1);
    send3(8'hA4, 8'h00, 8'h10); check_resp("thrsh", 1);

`ifdef HVDC_RAMP_EN
    begin
      int last_t, n_steps;
      logic [7:0] last_v;
      m_hvon = 1'b1; push_exp(1'b1);
      send3(8'hA1, 8'h00, 8'h02); check_resp("ramp.hvon", 1);
      push_exp(1'b1);
      send3(8'hA2, 8'h00, 8'h03); check_resp("ramp.wr", 1);
      last_v = hvdc_dac; last_t = -1; n_steps = 0;
      for (int t = 0; t < 12 * RDIV && n_steps < 3; t++) begin
        @(negedge clk);
        if (hvdc_dac !== last_v) begin
          chk("ramp.step", 32'(hvdc_dac), 32'(last_v + 8'd1));
          if (last_t >= 0) chk("ramp.interval", 32'(t - last_t), 32'(RDIV));
          last_v = hvdc_dac; last_t = t; n_steps++;
        end
      end
      chk("ramp.top", 32'(hvdc_dac), 32'(3));
      repeat (2 * RDIV) @(negedge clk);
      chk("ramp.hold", 32'(hvdc_dac), 32'(3));
      swin = 1'b0;
      for (int t = 0; t < 12 * RDIV && hvdc_dac != 8'd0; t++) @(negedge clk);
      chk("ramp.down", 32'(hvdc_dac), 32'(0));
      chk("ramp.hvon", 32'(hvon),     32'(0));
      m_hvon = 1'b0; swin = 1'b1;
    end
`endif

    // reset mid-command drops the partial command and all state
    send_byte(8'hA3); send_byte(8'h11);
    chk("midrst.busy_pre", 32'(busy), 32'(1));
    rst = 1'b1; #1;
    model_reset();
    chk("midrst.busy", 32'(busy), 32'(0));
    chk_regs("midrst");
    @(negedge clk); rst = 1'b0;
    m_bias = 8'h77; push_exp(1'b1);
    send3(8'hA3, 8'h00, 8'h77); check_resp("after_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
